// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs field-level requests into 32-bit words, buffers them
// in a FIFO and streams them to instruction memory. Optional macro: ENC_RANGE_CHECK_EN.
module instr_encoder #(
  parameter int                FIFO_DEPTH = 4,
  parameter int                ADDR_W     = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_fmt,
  input  logic [6:0]        req_opcode,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [2:0]        req_funct3,
  input  logic [6:0]        req_funct7,
  input  logic [31:0]       req_imm,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wr_data,
  input  logic              imem_wr_ready,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  logic [31:0]    fifo_mem [FIFO_DEPTH];
  logic [IDX_W:0] wr_ptr;
  logic [IDX_W:0] rd_ptr;
  logic           fifo_full;
  logic           accept;
  logic           push;
  logic           pop;
  logic           fmt_ok;
  logic           legal;
  logic [31:0]    enc_word;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign fifo_full = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                     (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign busy      = (wr_ptr != rd_ptr);
  assign req_ready = !fifo_full && !restart;
  assign accept    = req_valid && req_ready;
  assign push      = accept && legal;
  assign pop       = busy && imem_wr_ready;

  assign imem_wr_en   = busy;
  assign imem_wr_data = busy ? fifo_mem[rd_ptr[IDX_W-1:0]] : 32'd0;

  always_comb begin
    enc_word = 32'd0;
    fmt_ok   = 1'b1;
    case (req_fmt)
      FMT_R: enc_word = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, req_opcode};
      FMT_I: enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, req_opcode};
      FMT_S: enc_word = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], req_opcode};
      FMT_B: enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                         req_imm[4:1], req_imm[11], req_opcode};
      FMT_U: enc_word = {req_imm[31:12], req_rd, req_opcode};
      FMT_J: enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                         req_rd, req_opcode};
      default: fmt_ok = 1'b0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic range_ok;

  // An immediate fits when every bit above its sign bit copies the sign bit
  always_comb begin
    range_ok = 1'b1;
    case (req_fmt)
      FMT_I, FMT_S: range_ok = (&req_imm[31:11]) || !(|req_imm[31:11]);
      FMT_B:        range_ok = ((&req_imm[31:12]) || !(|req_imm[31:12])) && !req_imm[0];
      FMT_J:        range_ok = ((&req_imm[31:20]) || !(|req_imm[31:20])) && !req_imm[0];
      FMT_U:        range_ok = !(|req_imm[11:0]);
      default:      range_ok = 1'b1;
    endcase
  end

  assign legal = fmt_ok && range_ok;
`else
  assign legal = fmt_ok;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[IDX_W-1:0]] <= enc_word;
    end
  end

  // restart wins over push, pop and error capture in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      imem_addr <= BASE_ADDR;
      count     <= '0;
      err       <= 1'b0;
    end else if (restart) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      imem_addr <= BASE_ADDR;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (IDX_W+1)'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + (IDX_W+1)'(1);
        imem_addr <= imem_addr + ADDR_W'(1);
        if (count != COUNT_MAX) begin
          count <= count + (ADDR_W+1)'(1);
        end
      end
      if (accept && !legal) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed steps plus randomized requests checked
// against an arithmetic reference encoder and an expected-write queue.
module tb_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        restart;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_fmt;
  logic [6:0]  req_opcode;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [31:0] req_imm;
  logic        imem_wr_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wr_data;
  logic        imem_wr_ready;
  logic [10:0] count;
  logic        busy;
  logic        err;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_q[$];
  int exp_addr = 0;
  int exp_count = 0;
  logic exp_err = 1'b0;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .req_valid(req_valid), .req_ready(req_ready), .req_fmt(req_fmt),
    .req_opcode(req_opcode), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_funct3(req_funct3), .req_funct7(req_funct7), .req_imm(req_imm),
    .imem_wr_en(imem_wr_en), .imem_addr(imem_addr), .imem_wr_data(imem_wr_data),
    .imem_wr_ready(imem_wr_ready), .count(count), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference encoder built from bit positions with plain arithmetic
  function automatic logic [31:0] refEncode(input int fmt, input int unsigned opc,
      input int unsigned rd, input int unsigned rs1, input int unsigned rs2,
      input int unsigned f3, input int unsigned f7, input int imm);
    int unsigned u;
    int unsigned base;
    u = unsigned'(imm);
    base = (f3 << 12) | opc;
    case (fmt)
      0: return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | base | (rd << 7);
      1: return ((u % 4096) << 20) | (rs1 << 15) | base | (rd << 7);
      2: return (((u >> 5) % 128) << 25) | (rs2 << 20) | (rs1 << 15) | base | ((u % 32) << 7);
      3: return (((u >> 12) % 2) << 31) | (((u >> 5) % 64) << 25) | (rs2 << 20) |
                (rs1 << 15) | base | (((u >> 1) % 16) << 8) | (((u >> 11) % 2) << 7);
      4: return (u & 32'hFFFF_F000) | (rd << 7) | opc;
      5: return (((u >> 20) % 2) << 31) | (((u >> 1) % 1024) << 21) | (((u >> 11) % 2) << 20) |
                (((u >> 12) % 256) << 12) | (rd << 7) | opc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit refLegal(input int fmt, input int imm);
    if (fmt > 5) return 1'b0;
`ifdef ENC_RANGE_CHECK_EN
    case (fmt)
      1, 2: return (imm >= -2048) && (imm <= 2047);
      3:    return (imm >= -4096) && (imm <= 4095) && ((imm & 1) == 0);
      4:    return (imm & 32'hFFF) == 0;
      5:    return (imm >= -(1 << 20)) && (imm < (1 << 20)) && ((imm & 1) == 0);
      default: return 1'b1;
    endcase
`else
    return 1'b1;
`endif
  endfunction

  // Memory-side monitor: every completed write must match the next expected word/address
  initial begin
    logic [31:0] w;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && !restart && imem_wr_en && imem_wr_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_write", {32'd0, imem_wr_data}, 64'hDEAD);
        end else begin
          w = exp_q.pop_front();
          checkOutput("wr_data", {32'd0, imem_wr_data}, {32'd0, w});
          checkOutput("wr_addr", {54'd0, imem_addr}, 64'(exp_addr));
        end
        exp_addr = (exp_addr + 1) % 1024;
        if (exp_count < 1024) exp_count++;
      end
    end
  end

  task automatic idle();
    req_valid = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the request is accepted
  task automatic applyStimulus(input int fmt, input logic [6:0] opc, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input int imm, input bit use_lit, input logic [31:0] lit,
      input bit rnd_ready);
    bit acc;
    logic r;
    req_fmt = 3'(fmt);
    req_opcode = opc;
    req_rd = rd;
    req_rs1 = rs1;
    req_rs2 = rs2;
    req_funct3 = f3;
    req_funct7 = f7;
    req_imm = imm;
    req_valid = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 50 && !acc; c++) begin
      if (rnd_ready) imem_wr_ready = 1'($urandom_range(0, 1));
      #4;
      r = req_ready;
      @(posedge clk);
      if (r) begin
        acc = 1'b1;
        if (refLegal(fmt, imm))
          exp_q.push_back(use_lit ? lit : refEncode(fmt, opc, rd, rs1, rs2, f3, f7, imm));
        else
          exp_err = 1'b1;
      end
      @(negedge clk);
    end
    if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitIdle();
    idle();
    imem_wr_ready = 1'b1;
    for (int c = 0; c < 80 && busy; c++) @(negedge clk);
    checkOutput("drain_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic restartPulse();
    restart = 1'b1;
    #4;
    checkOutput("ready_in_restart", {63'd0, req_ready}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    restart = 1'b0;
    idle();
    exp_q.delete();
    exp_addr = 0;
    exp_count = 0;
    exp_err = 1'b0;
  endtask

  initial begin
    int fmt;
    int imm;
    rst_n = 1'b0;
    restart = 1'b0;
    req_valid = 1'b0;
    req_fmt = '0;
    req_opcode = '0;
    req_rd = '0;
    req_rs1 = '0;
    req_rs2 = '0;
    req_funct3 = '0;
    req_funct7 = '0;
    req_imm = '0;
    imem_wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_ready", {63'd0, req_ready}, 64'd1);
    checkOutput("rst_wr_en", {63'd0, imem_wr_en}, 64'd0);
    checkOutput("rst_addr", {54'd0, imem_addr}, 64'd0);
    checkOutput("rst_data", {32'd0, imem_wr_data}, 64'd0);
    checkOutput("rst_count", {53'd0, count}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_err", {63'd0, err}, 64'd0);

    $display("[TB] single I-type, one-cycle latency");
    applyStimulus(1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 5, 1'b1, 32'h0050_0093, 1'b0);
    idle();
    checkOutput("lat_wr_en", {63'd0, imem_wr_en}, 64'd1);
    checkOutput("lat_data", {32'd0, imem_wr_data}, 64'h0050_0093);
    checkOutput("lat_addr", {54'd0, imem_addr}, 64'd0);
    waitIdle();
    checkOutput("count_after_i", {53'd0, count}, 64'(exp_count));

    $display("[TB] back-to-back R/S/B/J stream");
    applyStimulus(0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 0, 1'b1, 32'h0020_81B3, 1'b0);
    applyStimulus(2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 8, 1'b1, 32'h0020_A423, 1'b0);
    applyStimulus(3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -4, 1'b1, 32'hFE20_8EE3, 1'b0);
    applyStimulus(5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 2048, 1'b1, 32'h0010_00EF, 1'b0);
    waitIdle();
    checkOutput("count_after_stream", {53'd0, count}, 64'd5);
    checkOutput("addr_after_stream", {54'd0, imem_addr}, 64'd5);

    $display("[TB] back-pressure: FIFO fills at four words");
    restartPulse();
    imem_wr_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, i * 3, 1'b0, 32'd0, 1'b0);
    req_fmt = 3'd1;
    req_valid = 1'b1;
    #1;
    checkOutput("full_ready", {63'd0, req_ready}, 64'd0);
    checkOutput("full_addr_hold", {54'd0, imem_addr}, 64'd0);
    checkOutput("full_data_hold", {32'd0, imem_wr_data}, {32'd0, exp_q[0]});
    @(negedge clk);
    imem_wr_ready = 1'b1;
    applyStimulus(1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 12, 1'b0, 32'd0, 1'b0);
    waitIdle();
    checkOutput("count_after_hold", {53'd0, count}, 64'd5);

    $display("[TB] restart with buffered words and err set");
    imem_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 7'h33, 5'(i), 5'(i + 1), 5'(i + 2), 3'd0, 7'd0, 0, 1'b0, 32'd0, 1'b0);
    applyStimulus(7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 0, 1'b0, 32'd0, 1'b0);
    idle();
    checkOutput("fmt7_err", {63'd0, err}, 64'd1);
    checkOutput("buffered_busy", {63'd0, busy}, 64'd1);
    req_fmt = 3'd1;
    req_valid = 1'b1;
    restartPulse();
    #1;
    checkOutput("restart_busy", {63'd0, busy}, 64'd0);
    checkOutput("restart_count", {53'd0, count}, 64'd0);
    checkOutput("restart_err", {63'd0, err}, 64'd0);
    checkOutput("restart_addr", {54'd0, imem_addr}, 64'd0);
    @(negedge clk);
    imem_wr_ready = 1'b1;
    applyStimulus(4, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b0, 32'd0, 1'b0);
    waitIdle();
    checkOutput("count_after_restart", {53'd0, count}, 64'd1);

    $display("[TB] I-type immediate 2048");
    applyStimulus(1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 2048, 1'b1, 32'h8000_0093, 1'b0);
    waitIdle();
    checkOutput("imm2048_err", {63'd0, err}, {63'd0, exp_err});
    checkOutput("imm2048_count", {53'd0, count}, 64'(exp_count));

    $display("[TB] randomized requests with random memory back-pressure");
    for (int n = 0; n < 80; n++) begin
      fmt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) imm = int'($urandom_range(0, 8191)) - 4096;
      else imm = int'($urandom);
      if ($urandom_range(0, 1) == 1) imm = imm & ~1;
      if (fmt == 4 && $urandom_range(0, 1) == 1) imm = imm & ~32'hFFF;
      applyStimulus(fmt, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                    3'($urandom), 7'($urandom), imm, 1'b0, 32'd0, 1'b1);
      if ($urandom_range(0, 3) == 0) idle();
    end
    waitIdle();
    checkOutput("rand_count", {53'd0, count}, 64'(exp_count));
    checkOutput("rand_addr", {54'd0, imem_addr}, 64'(exp_addr));
    checkOutput("rand_err", {63'd0, err}, {63'd0, exp_err});

    $display("[TB] reset asserted mid-stream");
    imem_wr_ready = 1'b0;
    applyStimulus(0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 0, 1'b0, 32'd0, 1'b0);
    applyStimulus(0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'd0, 0, 1'b0, 32'd0, 1'b0);
    idle();
    checkOutput("pre_reset_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", {63'd0, busy}, 64'd0);
    checkOutput("midrst_wr_en", {63'd0, imem_wr_en}, 64'd0);
    checkOutput("midrst_count", {53'd0, count}, 64'd0);
    checkOutput("midrst_addr", {54'd0, imem_addr}, 64'd0);
    exp_q.delete();
    exp_addr = 0;
    exp_count = 0;
    exp_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    imem_wr_ready = 1'b1;
    @(negedge clk);
    applyStimulus(1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd4, 7'd0, -1, 1'b0, 32'd0, 1'b0);
    waitIdle();
    checkOutput("post_reset_count", {53'd0, count}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
